// File: rtl/fmul_pipe.sv
// Elastic 3-stage floating-point multiplier: unpack/multiply, normalise/round, exception/pack.
// Valid/ready on both sides; each stage holds its content until the next stage can take it.
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [3:0]               out_flags,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam int P  = 2 * MAN_W + 2;
    localparam logic [EW-1:0]        BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);
    localparam logic [MAN_W-1:0]     QNAN_MAN = {1'b1, {(MAN_W-1){1'b0}}};

    // Handshake: a transfer happens on valid && ready at posedge; valid never waits on ready.
    logic v1, v2, v3;
    logic en1, en2, en3;

    assign en3       = !v3 || out_ready;
    assign en2       = !v2 || en3;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    // Stage 1: unpack and classify (subnormal inputs count as zero)
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_max, b_max, a_nan, b_nan;

    assign {sa, ea, ma} = in_a;
    assign {sb, eb, mb} = in_b;
    assign a_max = &ea;
    assign b_max = &eb;
    assign a_nan = a_max && (ma != '0);
    assign b_nan = b_max && (mb != '0);

    logic                    s1_sign, s1_nan, s1_snan, s1_inf, s1_zero;
    logic signed [EW-1:0]    s1_exp;
    logic [P-1:0]            s1_prod;
    logic [TAG_W-1:0]        s1_tag;

    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            s1_sign <= sa ^ sb;
            s1_exp  <= {2'b00, ea} + {2'b00, eb} - BIAS;
            s1_prod <= P'({1'b1, ma}) * P'({1'b1, mb});
            s1_nan  <= a_nan || b_nan;
            s1_snan <= (a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]);
            s1_inf  <= (a_max && (ma == '0)) || (b_max && (mb == '0));
            s1_zero <= (ea == '0) || (eb == '0);
            s1_tag  <= in_tag;
        end
    end

    // Stage 2: normalise so the leading one sits just above the kept fraction, then RNE
    logic [P-2:0]         norm;
    logic [MAN_W-1:0]     frac_t, frac_r;
    logic                 g_bit, s_bit, inc, carry;
    logic signed [EW-1:0] e_n;

    always_comb begin
        norm   = s1_prod[P-1] ? s1_prod[P-2:0] : {s1_prod[P-3:0], 1'b0};
        frac_t = norm[P-2 -: MAN_W];
        g_bit  = norm[MAN_W];
        s_bit  = |norm[MAN_W-1:0];
        inc    = g_bit && (s_bit || frac_t[0]);
        // A carry out leaves frac_r all zeros, which is exactly the renormalised fraction.
        {carry, frac_r} = {1'b0, frac_t} + (MAN_W+1)'(inc);
        e_n    = s1_exp + EW'(s1_prod[P-1]) + EW'(carry);
    end

    logic                 s2_sign, s2_nan, s2_snan, s2_inf, s2_zero, s2_inx;
    logic signed [EW-1:0] s2_exp;
    logic [MAN_W-1:0]     s2_frac;
    logic [TAG_W-1:0]     s2_tag;

    always_ff @(posedge clk) begin
        if (en2 && v1) begin
            s2_sign <= s1_sign;
            s2_exp  <= e_n;
            s2_frac <= frac_r;
            s2_inx  <= g_bit | s_bit;
            s2_nan  <= s1_nan;
            s2_snan <= s1_snan;
            s2_inf  <= s1_inf;
            s2_zero <= s1_zero;
            s2_tag  <= s1_tag;
        end
    end

    // Stage 3: exceptions in priority order, then pack
    logic [W-1:0] res;
    logic [3:0]   flg;

    always_comb begin
        res = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
        flg = {3'b000, s2_inx};
        if (s2_nan) begin
            res = {1'b0, {EXP_W{1'b1}}, QNAN_MAN};
            flg = {s2_snan, 3'b000};
        end else if (s2_inf && s2_zero) begin
            res = {1'b0, {EXP_W{1'b1}}, QNAN_MAN};
            flg = 4'b1000;
        end else if (s2_inf) begin
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg = 4'b0000;
        end else if (s2_zero) begin
            res = {s2_sign, {(W-1){1'b0}}};
            flg = 4'b0000;
        end else if (s2_exp >= E_MAX) begin
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg = 4'b0101;
        end else if (s2_exp[EW-1] || (s2_exp == '0)) begin
            res = {s2_sign, {(W-1){1'b0}}};
            flg = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            out_tag    <= '0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
            if (en3) v3 <= v2;
            if (en3 && v2) begin
                out_result <= res;
                out_flags  <= flg;
                out_tag    <= s2_tag;
            end
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe (binary32): vector table, backpressure stream, mid-flight reset.
module tb_fmul_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  out_tag;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    logic [35:0] exp_q[$];

    fmul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_tag    = v.tag;
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'd3);
        chk($sformatf("v%0d result", idx), out_result, v.res);
        chk($sformatf("v%0d flags", idx), 32'(out_flags), 32'(v.flg));
        chk($sformatf("v%0d tag", idx), 32'(out_tag), 32'(v.tag));
    endtask

    initial begin
        int sent, got, cyc, seen;
        logic [31:0] hold_res;
        logic [3:0]  hold_tag;
        logic [35:0] e;
        vec_t v;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 4'd5,  32'h40400000, 4'b0000};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 4'd1,  32'h3F800002, 4'b0001};
        vecs[2]  = '{32'h7F000000, 32'h40000000, 4'd2,  32'h7F800000, 4'b0101};
        vecs[3]  = '{32'h00800000, 32'h3F000000, 4'd3,  32'h00000000, 4'b0011};
        vecs[4]  = '{32'h7F800000, 32'h00000000, 4'd4,  32'h7FC00000, 4'b1000};
        vecs[5]  = '{32'hFF800000, 32'h40000000, 4'd5,  32'hFF800000, 4'b0000};
        vecs[6]  = '{32'h7F800001, 32'h3F800000, 4'd6,  32'h7FC00000, 4'b1000};
        vecs[7]  = '{32'h3FC00000, 32'h3FC00000, 4'd7,  32'h40100000, 4'b0000};
        vecs[8]  = '{32'h3FFFFFFE, 32'h3F800001, 4'd8,  32'h40000000, 4'b0001};
        vecs[9]  = '{32'h3FC00000, 32'h3F800001, 4'd9,  32'h3FC00002, 4'b0001};
        vecs[10] = '{32'h3F800002, 32'h3FA00000, 4'd10, 32'h3FA00002, 4'b0001};
        vecs[11] = '{32'hC0000000, 32'hC0400000, 4'd11, 32'h40C00000, 4'b0000};
        vecs[12] = '{32'h80000000, 32'h3F800000, 4'd12, 32'h80000000, 4'b0000};
        vecs[13] = '{32'h00000001, 32'h40000000, 4'd13, 32'h00000000, 4'b0000};
        vecs[14] = '{32'h7F000000, 32'h3F800000, 4'd14, 32'h7F000000, 4'b0000};
        vecs[15] = '{32'h00800000, 32'h3F800000, 4'd15, 32'h00800000, 4'b0000};
        vecs[16] = '{32'h7FC00000, 32'hFF800000, 4'd0,  32'h7FC00000, 4'b0000};
        vecs[17] = '{32'hFF800000, 32'h80000000, 4'd1,  32'h7FC00000, 4'b1000};

        // Clock/reset
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_result", out_result, 32'd0);
        chk("reset out_flags", 32'(out_flags), 32'd0);
        chk("reset out_tag", 32'(out_tag), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Six-op stream with out_ready held low for the first 5 cycles
        sent = 0; got = 0; cyc = 0;
        hold_res = '0; hold_tag = '0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            out_ready = (cyc > 5);
            in_valid  = (sent < 6);
            in_a      = 32'h3F800000;
            in_b      = 32'h40000000 + (32'(sent) << 20);
            in_tag    = 4'(sent);
            #1;
            if (cyc == 4) begin
                hold_res = out_result;
                hold_tag = out_tag;
                chk("stream out_valid held", 32'(out_valid), 32'd1);
            end
            if (cyc == 5) begin
                chk("stream accepts before stall", 32'(sent), 32'd3);
                chk("stream in_ready stalled", 32'(in_ready), 32'd0);
                chk("stream result stable", out_result, hold_res);
                chk("stream tag stable", 32'(out_tag), 32'(hold_tag));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, in_b});
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream extra output", 32'(out_tag), 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream tag %0d", got), 32'(out_tag), 32'(e[35:32]));
                    chk($sformatf("stream result %0d", got), out_result, e[31:0]);
                    chk($sformatf("stream flags %0d", got), 32'(out_flags), 32'd0);
                end
                got++;
            end
        end
        chk("stream outputs", 32'(got), 32'd6);
        chk("stream leftover", 32'(exp_q.size()), 32'd0);

        // Reset with two ops in flight
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 4'd1;
        @(negedge clk);
        in_tag = 4'd2;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset out_result", out_result, 32'd0);
        chk("midreset out_flags", 32'(out_flags), 32'd0);
        chk("midreset out_tag", 32'(out_tag), 32'd0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midreset dropped ops", 32'(seen), 32'd0);
        v = '{32'h3FC00000, 32'h40000000, 4'd9, 32'h40400000, 4'b0000};
        run_vec(v, 99);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
